// File: rtl/video_pattern_gen_if.sv
// video_pattern_gen_if: control inputs and video outputs of the pattern generator.
// The master side is the generator; the slave side is the control/video consumer.
interface video_pattern_gen_if #(
    parameter int DW = 8
);
    logic              enable;
    logic [1:0]        pattern_sel;
    logic [3*DW-1:0]   solid_rgb;
    logic              video_hs;
    logic              video_vs;
    logic              video_de;
    logic [3*DW-1:0]   video_rgb;
    logic [10:0]       pixel_xpos;
    logic [10:0]       pixel_ypos;
    logic              frame_start;
    logic [15:0]       frame_cnt;

    modport master (
        input  enable, pattern_sel, solid_rgb,
        output video_hs, video_vs, video_de, video_rgb,
               pixel_xpos, pixel_ypos, frame_start, frame_cnt
    );

    modport slave (
        output enable, pattern_sel, solid_rgb,
        input  video_hs, video_vs, video_de, video_rgb,
               pixel_xpos, pixel_ypos, frame_start, frame_cnt
    );
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: parametrised video timing plus colorbar/grid/gradient/solid test patterns.
// Build macro VPG_BORDER_EN adds a 1-pixel white border over the active area for every pattern.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int SYNC_POL = 1,
    parameter int DW       = 8,
    parameter int BARS     = 8,
    parameter int GRID     = 16
) (
    input  logic                pixel_clk,
    input  logic                sys_rst_n,
    video_pattern_gen_if.master vif
);
    localparam int CW   = 12;
    localparam int RGBW = 3 * DW;

    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0]   BAR_W     = 11'(H_ACTIVE / BARS);
    localparam logic [10:0]   BAR_MAX   = 11'(BARS - 1);
    localparam logic [10:0]   GRID_MASK = 11'(GRID - 1);
    localparam logic          SYNC_ON   = (SYNC_POL != 0);
`ifdef VPG_BORDER_EN
    localparam logic [CW-1:0] H_EDGE = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_EDGE = CW'(V_ACTIVE - 1);
`endif

    // Bar index -> {R,G,B} on/off bits: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_bits(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    function automatic logic [RGBW-1:0] pattern_rgb(input logic [1:0]      sel,
                                                     input logic [10:0]     x,
                                                     input logic [10:0]     y,
                                                     input logic [RGBW-1:0] solid);
        logic [10:0]     bar;
        logic [2:0]      c;
        logic [11:0]     sum;
        logic [RGBW-1:0] rgb;
        bar = x / BAR_W;
        sum = {1'b0, x} + {1'b0, y};
        case (sel)
            2'd0: begin
                if (bar > BAR_MAX) begin
                    c = bar_bits(BAR_MAX[2:0]);
                end else begin
                    c = bar_bits(bar[2:0]);
                end
                rgb = {{DW{c[2]}}, {DW{c[1]}}, {DW{c[0]}}};
            end
            2'd1: begin
                c   = 3'b000;
                rgb = (((x & GRID_MASK) == 11'd0) || ((y & GRID_MASK) == 11'd0)) ?
                      {RGBW{1'b1}} : {RGBW{1'b0}};
            end
            2'd2: begin
                c   = 3'b000;
                rgb = {x[DW-1:0], y[DW-1:0], sum[DW-1:0]};
            end
            default: begin
                c   = 3'b000;
                rgb = solid;
            end
        endcase
        return rgb;
    endfunction

    logic [CW-1:0]   h_q, h_d, v_q, v_d;
    logic [1:0]      pat_q, pat_d;
    logic [RGBW-1:0] solid_q, solid_d;
    logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [RGBW-1:0] rgb_q, rgb_d;
    logic [10:0]     xpos_q, xpos_d, ypos_q, ypos_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic            boundary_s, active_s;

    // Next state of the timing counters, frame-boundary latches and all video outputs.
    always_comb begin
        h_d        = ZERO_C;
        v_d        = ZERO_C;
        hs_d       = ~SYNC_ON;
        vs_d       = ~SYNC_ON;
        de_d       = 1'b0;
        rgb_d      = {RGBW{1'b0}};
        xpos_d     = 11'd0;
        ypos_d     = 11'd0;
        fs_d       = 1'b0;
        fcnt_d     = fcnt_q;
        boundary_s = (h_q == ZERO_C) && (v_q == ZERO_C);
        active_s   = (h_q < H_ACT) && (v_q < V_ACT);
        // The (0,0) pixel already uses the freshly latched selection, so frames never tear.
        if (boundary_s) begin
            pat_d   = vif.pattern_sel;
            solid_d = vif.solid_rgb;
        end else begin
            pat_d   = pat_q;
            solid_d = solid_q;
        end
        if (vif.enable) begin
            if (h_q == H_LAST) begin
                h_d = ZERO_C;
                if (v_q == V_LAST) begin
                    v_d    = ZERO_C;
                    fcnt_d = fcnt_q + 16'd1;
                end else begin
                    v_d    = v_q + ONE_C;
                    fcnt_d = fcnt_q;
                end
            end else begin
                h_d = h_q + ONE_C;
                v_d = v_q;
            end
            hs_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_ON : ~SYNC_ON;
            vs_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_ON : ~SYNC_ON;
            de_d = active_s;
            fs_d = active_s && boundary_s;
            if (active_s) begin
                xpos_d = h_q[10:0];
                ypos_d = v_q[10:0];
`ifdef VPG_BORDER_EN
                if ((h_q == ZERO_C) || (h_q == H_EDGE) || (v_q == ZERO_C) || (v_q == V_EDGE)) begin
                    rgb_d = {RGBW{1'b1}};
                end else begin
                    rgb_d = pattern_rgb(pat_d, h_q[10:0], v_q[10:0], solid_d);
                end
`else
                rgb_d = pattern_rgb(pat_d, h_q[10:0], v_q[10:0], solid_d);
`endif
            end else begin
                xpos_d = 11'd0;
                ypos_d = 11'd0;
                rgb_d  = {RGBW{1'b0}};
            end
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // State and output registers; asynchronous reset returns everything to the idle values.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_q     <= ZERO_C;
            v_q     <= ZERO_C;
            pat_q   <= 2'd0;
            solid_q <= {RGBW{1'b0}};
            hs_q    <= ~SYNC_ON;
            vs_q    <= ~SYNC_ON;
            de_q    <= 1'b0;
            rgb_q   <= {RGBW{1'b0}};
            xpos_q  <= 11'd0;
            ypos_q  <= 11'd0;
            fs_q    <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign vif.video_hs    = hs_q;
    assign vif.video_vs    = vs_q;
    assign vif.video_de    = de_q;
    assign vif.video_rgb   = rgb_q;
    assign vif.pixel_xpos  = xpos_q;
    assign vif.pixel_ypos  = ypos_q;
    assign vif.frame_start = fs_q;
    assign vif.frame_cnt   = fcnt_q;
endmodule
